// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the I2C serial-EEPROM slave.
// The optional write-protect pin is enabled with the EEPROM_WP_EN macro.
package i2c_eeprom_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CTRL,
    ST_CTRL_ACK,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_ADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WRCYC
  } state_e;

  localparam logic [3:0] DEV_TYPE = 4'b1010;
  localparam int         RW_BIT   = 0;

  // Mask selecting the in-page offset bits of a byte address.
  function automatic int page_mask(input int page_size);
    return (1 << $clog2(page_size)) - 1;
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA into the clk domain and produces single-cycle
// SCL edge strobes plus START/STOP condition pulses.
module i2c_bus_monitor (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s;
  logic       sda_s;

  // Idle bus is high on both lines, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SDA may only move while SCL is stably high for a bus condition.
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// Clocked I2C serial-EEPROM slave: byte/page write, current/random/sequential
// read, write-cycle busy with ACK polling. Optional wp pin via EEPROM_WP_EN.
module i2c_eeprom_slave
  import i2c_eeprom_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int ADDR_BYTES = 1,
  parameter int PAGE_SIZE  = 16,
  parameter int TWR_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  output logic busy
`ifdef EEPROM_WP_EN
  ,
  input  logic wp
`endif
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WCNT_W = (TWR_CYCLES > 1) ? $clog2(TWR_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(page_mask(PAGE_SIZE));

  logic sda_s, scl_rise, scl_fall, start, stop;
  logic wp_act;

`ifdef EEPROM_WP_EN
  assign wp_act = wp;
`else
  assign wp_act = 1'b0;
`endif

  i2c_bus_monitor u_mon (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start),
    .stop_o    (stop)
  );

  state_e              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          sr_q, sr_d;
  logic [7:0]          tx_q, tx_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [2:0]          ctrl_a_q, ctrl_a_d;
  logic [7:0]          addr_hi_q, addr_hi_d;
  logic                hi_seen_q, hi_seen_d;
  logic                rw_q, rw_d;
  logic                wrote_q, wrote_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                mem_we;
  logic [7:0]          rx_byte;
  logic [7:0]          mem_rdata;
  logic [ADDR_W-1:0]   page_inc;

  logic [7:0] mem_q [DEPTH];

  assign rx_byte   = {sr_q, sda_s};
  assign mem_rdata = mem_q[ptr_q];
  // Page writes roll over inside the page; upper address bits stay put.
  assign page_inc  = (ptr_q & ~PAGE_MASK) | ((ptr_q + ADDR_W'(1)) & PAGE_MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      ctrl_a_q  <= '0;
      addr_hi_q <= '0;
      hi_seen_q <= 1'b0;
      rw_q      <= 1'b0;
      wrote_q   <= 1'b0;
      wcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      ctrl_a_q  <= ctrl_a_d;
      addr_hi_q <= addr_hi_d;
      hi_seen_q <= hi_seen_d;
      rw_q      <= rw_d;
      wrote_q   <= wrote_d;
      wcnt_q    <= wcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q] <= rx_byte;
  end

  // bit_cnt 8 = waiting for the fall ending bit 8, 9 = in the ninth slot,
  // 10 = master ACKed a read byte and the slot is closing.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    ctrl_a_d  = ctrl_a_q;
    addr_hi_d = addr_hi_q;
    hi_seen_d = hi_seen_q;
    rw_d      = rw_q;
    wrote_d   = wrote_q;
    wcnt_d    = wcnt_q;
    mem_we    = 1'b0;
    if (state_q == ST_WRCYC) begin
      if (wcnt_q == '0) state_d = ST_IDLE;
      else              wcnt_d  = wcnt_q - WCNT_W'(1);
    end else if (start) begin
      state_d   = ST_CTRL;
      bit_cnt_d = '0;
    end else if (stop) begin
      if (wrote_q) begin
        state_d = ST_WRCYC;
        wcnt_d  = WCNT_W'(TWR_CYCLES - 1);
        wrote_d = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_CTRL, ST_ADDR_HI, ST_ADDR_LO, ST_WDATA: begin
          if (scl_rise) begin
            sr_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd8;
              case (state_q)
                ST_CTRL: begin
                  if (rx_byte[7:4] == DEV_TYPE) begin
                    ctrl_a_d = rx_byte[3:1];
                    rw_d     = rx_byte[RW_BIT];
                    state_d  = ST_CTRL_ACK;
                  end else begin
                    state_d = ST_IDLE;
                  end
                end
                ST_ADDR_HI: begin
                  addr_hi_d = rx_byte;
                  hi_seen_d = 1'b1;
                  state_d   = ST_ADDR_ACK;
                end
                ST_ADDR_LO: begin
                  ptr_d     = (ADDR_BYTES == 2) ? ADDR_W'({addr_hi_q, rx_byte})
                                                : ADDR_W'({ctrl_a_q, rx_byte});
                  hi_seen_d = 1'b0;
                  state_d   = ST_ADDR_ACK;
                end
                default: begin
                  if (wp_act) begin
                    state_d = ST_IDLE;
                  end else begin
                    mem_we  = 1'b1;
                    wrote_d = 1'b1;
                    ptr_d   = page_inc;
                    state_d = ST_WDATA_ACK;
                  end
                end
              endcase
            end
          end
        end
        ST_CTRL_ACK, ST_ADDR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = 4'd9;
            end else begin
              bit_cnt_d = '0;
              case (state_q)
                ST_CTRL_ACK: begin
                  if (rw_q) begin
                    state_d = ST_RDATA;
                    tx_d    = mem_rdata;
                  end else begin
                    state_d = (ADDR_BYTES == 2) ? ST_ADDR_HI : ST_ADDR_LO;
                  end
                end
                ST_ADDR_ACK: state_d = hi_seen_q ? ST_ADDR_LO : ST_WDATA;
                default:     state_d = ST_WDATA;
              endcase
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd8;
              ptr_d     = ptr_q + ADDR_W'(1);
              state_d   = ST_RDATA_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (scl_fall) begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
        ST_RDATA_ACK: begin
          if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd9;
          end else if (scl_rise && bit_cnt_q == 4'd9) begin
            if (sda_s) state_d   = ST_IDLE;
            else       bit_cnt_d = 4'd10;
          end else if (scl_fall && bit_cnt_q == 4'd10) begin
            state_d   = ST_RDATA;
            bit_cnt_d = '0;
            tx_d      = mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // The last read bit is held until SCL falls so SDA never moves while SCL is high.
  always_comb begin
    sda_oe = 1'b0;
    busy   = (state_q == ST_WRCYC);
    case (state_q)
      ST_CTRL_ACK, ST_ADDR_ACK, ST_WDATA_ACK: sda_oe = (bit_cnt_q == 4'd9);
      ST_RDATA:                               sda_oe = ~tx_q[7];
      ST_RDATA_ACK:                           sda_oe = (bit_cnt_q == 4'd8) && !tx_q[7];
      default:                                sda_oe = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: an open-drain bus model driven by a
// bit-level I2C master, with hand-computed expected bytes and ACKs.
module tb_i2c_eeprom_slave;

  localparam int TWR = 300;

  logic clk = 1'b0;
  logic rst_n;
  logic scl_m;
  logic sda_m;
  logic sda_oe;
  logic busy;
  logic sda_line;
`ifdef EEPROM_WP_EN
  logic wp = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_eeprom_slave #(
    .ADDR_W    (11),
    .ADDR_BYTES(1),
    .PAGE_SIZE (16),
    .TWR_CYCLES(TWR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scl_i (scl_m),
    .sda_i (sda_line),
    .sda_oe(sda_oe),
    .busy  (busy)
`ifdef EEPROM_WP_EN
    ,
    .wp    (wp)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic hc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; hc(4);
    scl_m = 1'b1; hc(8);
    sda_m = 1'b0; hc(8);
    scl_m = 1'b0; hc(4);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; hc(4);
    scl_m = 1'b1; hc(8);
    sda_m = 1'b1; hc(1);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; hc(4);
      scl_m = 1'b1; hc(8);
      scl_m = 1'b0; hc(4);
    end
    sda_m = 1'b1; hc(4);
    scl_m = 1'b1; hc(4);
    ack = (sda_line === 1'b0);
    hc(4);
    scl_m = 1'b0; hc(4);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      hc(4);
      scl_m = 1'b1; hc(4);
      b[i] = sda_line;
      hc(4);
      scl_m = 1'b0; hc(4);
    end
    sda_m = nack; hc(4);
    scl_m = 1'b1; hc(8);
    scl_m = 1'b0; hc(4);
  endtask

  // START, control(write), address, repeated START, control(read).
  task automatic read_setup(input logic [7:0] ctrl, input logic [7:0] addr, output logic ok);
    logic a0, a1, a2;
    i2c_start;
    write_byte(ctrl, a0);
    write_byte(addr, a1);
    i2c_start;
    write_byte(ctrl | 8'h01, a2);
    ok = a0 & a1 & a2;
  endtask

  task automatic wait_busy_high(output logic ok);
    int n = 0;
    while (busy !== 1'b1 && n < 20) begin hc(1); n++; end
    ok = (busy === 1'b1);
  endtask

  task automatic wait_busy_low(output logic ok);
    int n = 0;
    while (busy !== 1'b0 && n < TWR + 50) begin hc(1); n++; end
    ok = (busy === 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic a0, a1, a2, ok;
    logic [7:0] v;
    logic [7:0] d;
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    hc(5);
    checks++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1; hc(5);
    i2c_start; write_byte(8'hA0, a0); write_byte(8'h00, a1); write_byte(8'h3C, a2); i2c_stop;
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL reset_write_acks: got %b expected 111", {a0, a1, a2}); end
    wait_busy_high(ok);
    rst_n = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || !ok) begin errors++; $display("FAIL reset_abandons_wrcyc: busy %b seen_busy %b expected 0 1", busy, ok); end
    hc(2); rst_n = 1'b1; hc(4);
    // Hold reset while the slave drives the control-byte ACK.
    i2c_start;
    v = 8'hA1;
    for (int i = 7; i >= 0; i--) begin
      sda_m = v[i]; hc(4);
      scl_m = 1'b1; hc(8);
      scl_m = 1'b0; hc(4);
    end
    sda_m = 1'b1;
    checks++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL reset_pre_ack: got %b expected 1", sda_oe); end
    rst_n = 1'b0; #1;
    checks++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_mid_byte_sda_oe: got %b expected 0", sda_oe); end
    scl_m = 1'b1; hc(2); rst_n = 1'b1; hc(4);
    i2c_start; write_byte(8'hA1, a0); read_byte(1'b1, d); i2c_stop; hc(4);
    checks++;
    if (a0 !== 1'b1 || d !== 8'h3C) begin errors++; $display("FAIL reset_cur_read: ack %b data %h expected 1 3c", a0, d); end
  endtask

  task automatic test_byte_write;
    logic a0, a1, a2, ok;
    logic [7:0] d;
    int cnt;
    i2c_start; write_byte(8'hA2, a0); write_byte(8'h23, a1); write_byte(8'h55, a2); i2c_stop;
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL byte_write_acks: got %b expected 111", {a0, a1, a2}); end
    wait_busy_high(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_rise: got %b expected 1", busy); end
    cnt = 0;
    while (busy === 1'b1 && cnt < TWR + 20) begin cnt++; hc(1); end
    checks++;
    if (cnt != TWR) begin errors++; $display("FAIL busy_length: got %0d expected %0d", cnt, TWR); end
    read_setup(8'hA2, 8'h23, ok); read_byte(1'b1, d); i2c_stop; hc(4);
    checks++;
    if (!ok || d !== 8'h55) begin errors++; $display("FAIL byte_write_readback: acks %b data %h expected 1 55", ok, d); end
  endtask

  task automatic test_page_write;
    logic a, all_ack, ok;
    logic [7:0] d;
    all_ack = 1'b1;
    i2c_start;
    write_byte(8'hA0, a); all_ack &= a;
    write_byte(8'h0E, a); all_ack &= a;
    for (int k = 0; k < 18; k++) begin write_byte(8'(k), a); all_ack &= a; end
    i2c_stop;
    checks++;
    if (all_ack !== 1'b1) begin errors++; $display("FAIL page_write_acks: got %b expected 1", all_ack); end
    hc(4); wait_busy_low(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL page_write_busy_timeout: busy %b expected 0", busy); end
    read_setup(8'hA0, 8'h00, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL page_read_setup_acks: got %b expected 1", ok); end
    // 0x0E/0x0F hold 0x10/0x11, 0x00..0x0D hold 0x02..0x0F: mem[k] = k + 2.
    for (int k = 0; k < 16; k++) begin
      read_byte(k == 15, d);
      checks++;
      if (d !== 8'(k + 2)) begin errors++; $display("FAIL page_read_%0d: got %h expected %h", k, d, 8'(k + 2)); end
    end
    i2c_stop; hc(4);
  endtask

  task automatic test_ack_polling;
    logic a0, a1, a2, a3, ok;
    i2c_start; write_byte(8'hAE, a0); write_byte(8'hFE, a1); write_byte(8'hA5, a2); write_byte(8'h5A, a3); i2c_stop;
    checks++;
    if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL poll_write_acks: got %b expected 1111", {a0, a1, a2, a3}); end
    hc(4);
    i2c_start; write_byte(8'hA0, a0); i2c_stop;
    checks++;
    if (a0 !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL poll_nack_busy: ack %b busy %b expected 0 1", a0, busy); end
    wait_busy_low(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL poll_busy_timeout: busy %b expected 0", busy); end
    hc(4);
    i2c_start; write_byte(8'hA0, a0); i2c_stop; hc(10);
    checks++;
    if (a0 !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL poll_ack_after: ack %b busy %b expected 1 0", a0, busy); end
  endtask

  task automatic test_seq_read;
    logic ok;
    logic [7:0] d;
    logic [7:0] exp_b [4];
    int drove;
    exp_b[0] = 8'hA5; exp_b[1] = 8'h5A; exp_b[2] = 8'h02; exp_b[3] = 8'h03;
    read_setup(8'hAE, 8'hFE, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL seq_setup_acks: got %b expected 1", ok); end
    for (int k = 0; k < 4; k++) begin
      read_byte(k == 3, d);
      checks++;
      if (d !== exp_b[k]) begin errors++; $display("FAIL seq_read_%0d: got %h expected %h", k, d, exp_b[k]); end
    end
    drove = 0;
    for (int k = 0; k < 20; k++) begin
      if (sda_oe !== 1'b0) drove++;
      hc(1);
    end
    checks++;
    if (drove != 0) begin errors++; $display("FAIL seq_nack_release: got %0d driven cycles expected 0", drove); end
    i2c_stop; hc(4);
  endtask

  task automatic test_wrong_device;
    logic a0, a1;
    logic [7:0] d;
    i2c_start; write_byte(8'hB0, a0); write_byte(8'h12, a1); i2c_stop; hc(4);
    checks++;
    if (a0 !== 1'b0 || a1 !== 1'b0) begin errors++; $display("FAIL wrong_dev_nack: got %b%b expected 00", a0, a1); end
    i2c_start; write_byte(8'hB1, a0); read_byte(1'b1, d); i2c_stop; hc(10);
    checks++;
    if (a0 !== 1'b0 || d !== 8'hFF || busy !== 1'b0) begin
      errors++; $display("FAIL wrong_dev_read: ack %b data %h busy %b expected 0 ff 0", a0, d, busy);
    end
    // Pointer left at 0x002 by the sequential read; mem[0x002] = 0x04.
    i2c_start; write_byte(8'hA1, a0); read_byte(1'b1, d); i2c_stop; hc(4);
    checks++;
    if (a0 !== 1'b1 || d !== 8'h04) begin errors++; $display("FAIL wrong_dev_ptr: ack %b data %h expected 1 04", a0, d); end
  endtask

`ifdef EEPROM_WP_EN
  task automatic test_write_protect;
    logic a0, a1, a2, ok;
    logic [7:0] d;
    wp = 1'b1;
    i2c_start; write_byte(8'hA2, a0); write_byte(8'h23, a1); write_byte(8'h77, a2); i2c_stop; hc(10);
    checks++;
    if ({a0, a1, a2} !== 3'b110 || busy !== 1'b0) begin
      errors++; $display("FAIL wp_acks_busy: acks %b busy %b expected 110 0", {a0, a1, a2}, busy);
    end
    wp = 1'b0;
    read_setup(8'hA2, 8'h23, ok); read_byte(1'b1, d); i2c_stop; hc(4);
    checks++;
    if (!ok || d !== 8'h55) begin errors++; $display("FAIL wp_unchanged: acks %b data %h expected 1 55", ok, d); end
  endtask
`endif

  initial begin
    test_reset;
    test_byte_write;
    test_page_write;
    test_ack_polling;
    test_seq_read;
    test_wrong_device;
`ifdef EEPROM_WP_EN
    test_write_protect;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
